// File: rtl/can_pkg.sv
// rtl/can_pkg.sv - shared types and frame layout for the CAN transmit dispatcher
package can_pkg;

    localparam int MSG_W = 128;

    localparam int ID_MSB   = 127;
    localparam int ID_LSB   = 99;
    localparam int IDE_BIT  = 98;
    localparam int RTR_BIT  = 97;
    localparam int DLC_MSB  = 96;
    localparam int DLC_LSB  = 93;
    localparam int RSVD_MSB = 92;
    localparam int RSVD_LSB = 64;
    localparam int DATA_MSB = 63;
    localparam int DATA_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_CAPTURE,
        ST_REQ,
        ST_ACTIVE,
        ST_BUSOFF
    } tx_state_t;

    function automatic logic [3:0] frame_dlc(input logic [MSG_W-1:0] frame);
        return frame[DLC_MSB:DLC_LSB];
    endfunction

endpackage

// File: rtl/can_tx_msg_dispatcher_if.sv
// rtl/can_tx_msg_dispatcher_if.sv - TX FIFO read port and transmit-engine handshake bundle
interface can_tx_msg_dispatcher_if;
    import can_pkg::*;

    logic             i_tx_empty;
    logic             o_tx_r_en;
    logic [MSG_W-1:0] i_tx_fifo_r_data;
    logic             o_tx_req;
    logic [MSG_W-1:0] o_tx_message;
    logic             i_tx_ack;
    logic             i_tx_done;
    logic             i_arb_lost;
    logic             i_tx_error;

    modport master (
        input  i_tx_empty, i_tx_fifo_r_data, i_tx_ack, i_tx_done, i_arb_lost, i_tx_error,
        output o_tx_r_en, o_tx_req, o_tx_message
    );

    modport slave (
        output i_tx_empty, i_tx_fifo_r_data, i_tx_ack, i_tx_done, i_arb_lost, i_tx_error,
        input  o_tx_r_en, o_tx_req, o_tx_message
    );

endinterface

// File: rtl/can_tx_retry_ctr.sv
// rtl/can_tx_retry_ctr.sv - per-frame error retry counter with limit flag
module can_tx_retry_ctr #(
    parameter int MAX_RETRIES = 8
) (
    input  logic       i_sys_clk,
    input  logic       i_reset_n,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic [3:0] cnt_o,
    output logic       limit_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    assign limit_o = (cnt_q == 4'(MAX_RETRIES - 1));
    assign cnt_o   = cnt_q;

    // Increment is gated by the limit so the count can never pass MAX_RETRIES-1.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 4'd0;
        end else if (inc_i && !limit_o) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/can_tx_msg_dispatcher.sv
// rtl/can_tx_msg_dispatcher.sv - pops TX frames and runs the request/ack/done handshake with retry
module can_tx_msg_dispatcher
    import can_pkg::*;
#(
    parameter int MAX_RETRIES = 8
) (
    input  logic                          i_sys_clk,
    input  logic                          i_reset_n,
    can_tx_msg_dispatcher_if.master       tx_if,
    input  logic                          i_single_shot,
    input  logic                          i_bus_off,
    output logic                          o_tx_done_pulse,
    output logic                          o_tx_abort_pulse,
    output logic [3:0]                    o_retry_cnt,
    output logic                          o_busy
);

    tx_state_t        state_q;
    logic             req_q;
    logic             done_q;
    logic             abort_q;
    logic [MSG_W-1:0] msg_q;

    logic retry_clr;
    logic retry_inc;
    logic retry_limit;

    // An error consumes a retry only when it is the winning event and retransmission is allowed.
    assign retry_clr = (state_q == ST_CAPTURE);
    assign retry_inc = (state_q == ST_ACTIVE) && !tx_if.i_tx_done && !i_bus_off &&
                       tx_if.i_tx_error && !i_single_shot;

    can_tx_retry_ctr #(
        .MAX_RETRIES (MAX_RETRIES)
    ) u_retry_ctr (
        .i_sys_clk (i_sys_clk),
        .i_reset_n (i_reset_n),
        .clr_i     (retry_clr),
        .inc_i     (retry_inc),
        .cnt_o     (o_retry_cnt),
        .limit_o   (retry_limit)
    );

    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            msg_q   <= '0;
        end else begin
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_bus_off) begin
                        state_q <= ST_BUSOFF;
                    end else if (!tx_if.i_tx_empty) begin
                        state_q <= ST_READ;
                    end
                end
                ST_READ: begin
                    state_q <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    msg_q   <= tx_if.i_tx_fifo_r_data;
                    req_q   <= 1'b1;
                    state_q <= ST_REQ;
                end
                ST_REQ: begin
                    if (i_bus_off) begin
                        req_q   <= 1'b0;
                        abort_q <= 1'b1;
                        state_q <= ST_BUSOFF;
                    end else if (tx_if.i_tx_ack) begin
                        req_q   <= 1'b0;
                        state_q <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (tx_if.i_tx_done) begin
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end else if (i_bus_off) begin
                        abort_q <= 1'b1;
                        state_q <= ST_BUSOFF;
                    end else if (tx_if.i_tx_error) begin
                        if (i_single_shot || retry_limit) begin
                            abort_q <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            req_q   <= 1'b1;
                            state_q <= ST_REQ;
                        end
                    end else if (tx_if.i_arb_lost) begin
                        if (i_single_shot) begin
                            abort_q <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            req_q   <= 1'b1;
                            state_q <= ST_REQ;
                        end
                    end
                end
                ST_BUSOFF: begin
                    if (!i_bus_off) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_if.o_tx_r_en    = (state_q == ST_READ);
    assign tx_if.o_tx_req     = req_q;
    assign tx_if.o_tx_message = msg_q;
    assign o_tx_done_pulse    = done_q;
    assign o_tx_abort_pulse   = abort_q;
    assign o_busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_can_tx_msg_dispatcher.sv
// tb/tb_can_tx_msg_dispatcher.sv - randomized self-checking bench with transaction-level reference model
module tb_can_tx_msg_dispatcher;
    import can_pkg::*;

    localparam int MAX_RETRIES = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       single_shot = 1'b0;
    logic       bus_off = 1'b0;
    logic       done_pulse;
    logic       abort_pulse;
    logic [3:0] retry_cnt;
    logic       busy;

    can_tx_msg_dispatcher_if ifc ();

    can_tx_msg_dispatcher #(
        .MAX_RETRIES (MAX_RETRIES)
    ) dut (
        .i_sys_clk        (clk),
        .i_reset_n        (rst_n),
        .tx_if            (ifc),
        .i_single_shot    (single_shot),
        .i_bus_off        (bus_off),
        .o_tx_done_pulse  (done_pulse),
        .o_tx_abort_pulse (abort_pulse),
        .o_retry_cnt      (retry_cnt),
        .o_busy           (busy)
    );

    always #5 clk = ~clk;

    // FIFO model: registered read data, one pop per read strobe
    logic [MSG_W-1:0] mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign ifc.i_tx_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (ifc.o_tx_r_en) begin
            ifc.i_tx_fifo_r_data <= mem[rd_ptr[7:0]];
            rd_ptr <= rd_ptr + 1;
        end
    end

    int n_done = 0, n_abort = 0, n_pop = 0, n_req = 0;
    logic req_prev = 1'b0;
    always @(posedge clk) begin
        if (done_pulse)  n_done  <= n_done + 1;
        if (abort_pulse) n_abort <= n_abort + 1;
        if (ifc.o_tx_r_en) n_pop <= n_pop + 1;
        if (ifc.o_tx_req && !req_prev) n_req <= n_req + 1;
        req_prev <= ifc.o_tx_req;
    end

    int n_checks = 0;
    int n_errors = 0;
    int exp_done = 0;
    int exp_abort = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [MSG_W-1:0] f);
        mem[wr_ptr[7:0]] = f;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (ifc.o_tx_req) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        chk("req_wait", ok, 1'b1);
    endtask

    task automatic pulse_ev(input logic [2:0] ev);
        ifc.i_tx_done  = ev[0];
        ifc.i_tx_error = ev[1];
        ifc.i_arb_lost = ev[2];
        tick(1);
        ifc.i_tx_done  = 1'b0;
        ifc.i_tx_error = 1'b0;
        ifc.i_arb_lost = 1'b0;
    endtask

    task automatic ack_once(input int dly);
        tick(dly);
        ifc.i_tx_ack = 1'b1;
        tick(1);
        ifc.i_tx_ack = 1'b0;
        chk("req_drop_on_ack", ifc.o_tx_req, 1'b0);
    endtask

    // Events: bit0 done, bit1 error, bit2 arbitration lost. Outcome follows done > error > arb priority.
    task automatic run_frame(input logic [MSG_W-1:0] f, input bit ss, input logic [2:0] evs[$],
                             input int ack_dly, input int ev_dly);
        int retries = 0, attempts = 0, fin = 0, idx = 0;
        int d0, a0, r0;
        bit ok;
        logic [2:0] ev;
        single_shot = ss;
        d0 = n_done; a0 = n_abort; r0 = n_req;
        while (fin == 0) begin
            wait_req(ok);
            if (!ok) return;
            attempts++;
            chk("retry_cnt", retry_cnt, 4'(retries));
            chk("message", ifc.o_tx_message, f);
            ack_once(ack_dly);
            tick(ev_dly);
            ev = (idx < evs.size()) ? evs[idx] : 3'b001;
            idx++;
            pulse_ev(ev);
            if (ev[0]) fin = 1;
            else if (ev[1]) begin
                if (ss || retries == MAX_RETRIES - 1) fin = 2;
                else retries++;
            end else if (ev[2]) begin
                if (ss) fin = 2;
            end
            chk("done_pulse", done_pulse, fin == 1);
            chk("abort_pulse", abort_pulse, fin == 2);
        end
        tick(1);
        chk("done_count", n_done - d0, (fin == 1) ? 1 : 0);
        chk("abort_count", n_abort - a0, (fin == 2) ? 1 : 0);
        chk("req_count", n_req - r0, attempts);
        chk("retry_hold", retry_cnt, 4'(retries));
        if (fin == 1) exp_done++;
        else exp_abort++;
        single_shot = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0]       evq[$];
        logic [MSG_W-1:0] f;
        logic [MSG_W-1:0] batch[3];
        int               p0, nb;
        bit               ok;

        ifc.i_tx_ack = 1'b0;
        ifc.i_tx_done = 1'b0;
        ifc.i_tx_error = 1'b0;
        ifc.i_arb_lost = 1'b0;
        tick(3);
        chk("rst_busy", busy, 1'b0);
        chk("rst_req", ifc.o_tx_req, 1'b0);
        chk("rst_r_en", ifc.o_tx_r_en, 1'b0);
        chk("rst_msg", ifc.o_tx_message, '0);
        chk("rst_retry", retry_cnt, 4'd0);
        chk("rst_pulses", {done_pulse, abort_pulse}, 2'b00);
        rst_n = 1'b1;
        tick(2);

        // Read/request latency, then ack and done
        f = 128'h12345678_9ABCDEF0_0F1E2D3C_000000AA;
        push(f);
        tick(1);
        chk("lat_r_en_c1", ifc.o_tx_r_en, 1'b1);
        chk("lat_req_c1", ifc.o_tx_req, 1'b0);
        tick(1);
        chk("lat_r_en_c2", ifc.o_tx_r_en, 1'b0);
        chk("lat_req_c2", ifc.o_tx_req, 1'b0);
        tick(1);
        chk("lat_req_c3", ifc.o_tx_req, 1'b1);
        evq = '{3'b001};
        run_frame(f, 1'b0, evq, 1, 14);
        chk("t1_idle", busy, 1'b0);

        // Error retries up to the limit, single FIFO pop
        p0 = n_pop;
        f = {$urandom, $urandom, $urandom, $urandom};
        push(f);
        evq = {};
        for (int i = 0; i < MAX_RETRIES; i++) evq.push_back(3'b010);
        run_frame(f, 1'b0, evq, 0, 2);
        chk("t2_one_pop", n_pop - p0, 1);
        chk("t2_idle", busy, 1'b0);

        // Arbitration loss: retransmit, then single-shot abort
        f = {$urandom, $urandom, $urandom, $urandom};
        push(f);
        evq = '{3'b100, 3'b100, 3'b100, 3'b001};
        run_frame(f, 1'b0, evq, 2, 1);
        f = {$urandom, $urandom, $urandom, $urandom};
        push(f);
        evq = '{3'b100};
        run_frame(f, 1'b1, evq, 1, 1);

        // Done and error together
        f = {$urandom, $urandom, $urandom, $urandom};
        push(f);
        evq = '{3'b011};
        run_frame(f, 1'b0, evq, 0, 0);

        // Bus-off while in REQ
        f = {$urandom, $urandom, $urandom, $urandom};
        push(f);
        wait_req(ok);
        bus_off = 1'b1;
        tick(1);
        chk("req_busoff_abort", abort_pulse, 1'b1);
        chk("req_busoff_req", ifc.o_tx_req, 1'b0);
        exp_abort++;
        bus_off = 1'b0;
        tick(3);

        // Bus-off while ACTIVE, FIFO held off until release
        f = {$urandom, $urandom, $urandom, $urandom};
        push(f);
        wait_req(ok);
        ack_once(0);
        tick(2);
        bus_off = 1'b1;
        tick(1);
        chk("act_busoff_abort", abort_pulse, 1'b1);
        exp_abort++;
        f = {$urandom, $urandom, $urandom, $urandom};
        push(f);
        p0 = n_pop;
        tick(50);
        chk("busoff_no_pop", n_pop - p0, 0);
        chk("busoff_busy", busy, 1'b1);
        chk("busoff_req", ifc.o_tx_req, 1'b0);
        bus_off = 1'b0;
        tick(2);
        chk("busoff_exit_read", ifc.o_tx_r_en, 1'b1);
        evq = '{3'b010, 3'b001};
        run_frame(f, 1'b0, evq, 1, 1);

        // Asynchronous reset mid-frame
        f = {$urandom, $urandom, $urandom, $urandom};
        push(f);
        wait_req(ok);
        ack_once(0);
        pulse_ev(3'b010);
        wait_req(ok);
        chk("pre_rst_retry", retry_cnt, 4'd1);
        ack_once(0);
        tick(2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_req", ifc.o_tx_req, 1'b0);
        chk("arst_msg", ifc.o_tx_message, '0);
        chk("arst_retry", retry_cnt, 4'd0);
        chk("arst_r_en", ifc.o_tx_r_en, 1'b0);
        tick(1);
        rst_n = 1'b1;
        p0 = n_pop;
        tick(6);
        chk("post_rst_idle", busy, 1'b0);
        chk("post_rst_no_pop", n_pop - p0, 0);

        // Randomized frames and event sequences
        for (int b = 0; b < 12; b++) begin
            nb = $urandom_range(1, 3);
            for (int k = 0; k < nb; k++) begin
                batch[k] = {$urandom, $urandom, $urandom, $urandom};
                push(batch[k]);
            end
            for (int k = 0; k < nb; k++) begin
                evq = {};
                for (int e = 0; e < $urandom_range(1, 12); e++) begin
                    case ($urandom % 8)
                        0, 1, 2, 3: evq.push_back(3'b010);
                        4, 5:       evq.push_back(3'b100);
                        6:          evq.push_back(3'b001);
                        default:    evq.push_back(3'($urandom_range(1, 7)));
                    endcase
                end
                run_frame(batch[k], ($urandom % 4) == 0, evq, $urandom_range(0, 3), $urandom_range(0, 4));
            end
        end

        tick(4);
        chk("total_pops", n_pop, wr_ptr);
        chk("fifo_drained", rd_ptr, wr_ptr);
        chk("total_done", n_done, exp_done);
        chk("total_abort", n_abort, exp_abort);
        chk("final_idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
